word_byte_transfer_unit: RTL and testbench

Sequencer that moves one DATA_WIDTH-bit word between the datapath and the byte-wide Memory over consecutive cycles. It is the parametrised successor of the fixed low/high byte select on the memory write path and the LH half-load of the IR. It sits between the ALU/register outputs and the Memory block and drives Memory's Address/Data/WR/CS pins during a transfer. It supports load and store, configurable word width, and configurable byte order.

---
 rtl/word_byte_transfer_unit_pkg.sv | 18 +
 rtl/word_byte_transfer_unit_if.sv | 31 +++
 rtl/word_byte_transfer_unit_byte_lane_select.sv | 32 +++
 rtl/word_byte_transfer_unit.sv | 132 +++++++++++++
 tb/tb_word_byte_transfer_unit.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/word_byte_transfer_unit_pkg.sv
// Shared op/state encodings and sizing helper for the word/byte transfer unit.
package wtu_pkg;

    localparam logic OP_LOAD  = 1'b0;
    localparam logic OP_STORE = 1'b1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } state_e;

    function automatic int unsigned idx_width(input int unsigned data_width);
        int unsigned n;
        n = data_width / 8;
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/word_byte_transfer_unit_if.sv
// Datapath/memory bus of the word/byte transfer unit; NextAddr exists only with WTU_AUTOINC_EN.
interface word_byte_transfer_unit_if #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 16
);
    logic                  Start;
    logic                  Op;
    logic [ADDR_WIDTH-1:0] BaseAddr;
    logic [DATA_WIDTH-1:0] WrData;
    logic [DATA_WIDTH-1:0] RdData;
    logic                  Busy;
    logic                  Done;
    logic [ADDR_WIDTH-1:0] Mem_Address;
    logic [7:0]            Mem_Data;
    logic                  Mem_WR;
    logic                  Mem_CS;
    logic [7:0]            MemOut;
`ifdef WTU_AUTOINC_EN
    logic [ADDR_WIDTH-1:0] NextAddr;

    modport slave  (input  Start, Op, BaseAddr, WrData, MemOut,
                    output RdData, Busy, Done, Mem_Address, Mem_Data, Mem_WR, Mem_CS, NextAddr);
    modport master (output Start, Op, BaseAddr, WrData, MemOut,
                    input  RdData, Busy, Done, Mem_Address, Mem_Data, Mem_WR, Mem_CS, NextAddr);
`else
    modport slave  (input  Start, Op, BaseAddr, WrData, MemOut,
                    output RdData, Busy, Done, Mem_Address, Mem_Data, Mem_WR, Mem_CS);
    modport master (output Start, Op, BaseAddr, WrData, MemOut,
                    input  RdData, Busy, Done, Mem_Address, Mem_Data, Mem_WR, Mem_CS);
`endif
endinterface

// File: rtl/word_byte_transfer_unit_byte_lane_select.sv
// Maps byte index to word lane: store byte mux plus one-hot load lane enable.
module byte_lane_select
    import wtu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter bit          BIG_ENDIAN = 1'b0,
    localparam int unsigned N     = DATA_WIDTH / 8,
    localparam int unsigned IDX_W = idx_width(DATA_WIDTH)
) (
    input  logic [IDX_W-1:0]      idx,
    input  logic [DATA_WIDTH-1:0] wr_word,
    output logic [7:0]            wr_byte,
    output logic [N-1:0]          lane_we
);

    int unsigned idx_u;
    int unsigned lane;

    always_comb begin
        wr_byte = '0;
        lane_we = '0;
        idx_u   = 32'(idx);
        lane    = BIG_ENDIAN ? (N - 1 - idx_u) : idx_u;
        for (int unsigned l = 0; l < N; l++) begin
            if (l == lane) begin
                wr_byte    = wr_word[8*l +: 8];
                lane_we[l] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/word_byte_transfer_unit.sv
// Moves one DATA_WIDTH word to/from byte-wide memory over N cycles.
// Define WTU_AUTOINC_EN to add the registered NextAddr post-increment output.
module word_byte_transfer_unit
    import wtu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter bit          BIG_ENDIAN = 1'b0
) (
    input  logic                      Clock,
    input  logic                      Reset,
    word_byte_transfer_unit_if.slave  bus
);

    localparam int unsigned N     = DATA_WIDTH / 8;
    localparam int unsigned IDX_W = idx_width(DATA_WIDTH);

    state_e                state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  op_q, op_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] asm_q, asm_d;
    logic [DATA_WIDTH-1:0] rd_q, rd_d;
    logic                  done_q, done_d;
`ifdef WTU_AUTOINC_EN
    logic [ADDR_WIDTH-1:0] next_addr_q, next_addr_d;
`endif

    logic [7:0]   lane_byte;
    logic [N-1:0] lane_we;
    logic         busy;
    logic         last;

    byte_lane_select #(
        .DATA_WIDTH (DATA_WIDTH),
        .BIG_ENDIAN (BIG_ENDIAN)
    ) u_lane (
        .idx     (idx_q),
        .wr_word (wdata_q),
        .wr_byte (lane_byte),
        .lane_we (lane_we)
    );

    assign busy = (state_q == ST_XFER);
    assign last = (idx_q == IDX_W'(N - 1));

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        asm_d   = asm_q;
        rd_d    = rd_q;
        done_d  = 1'b0;
`ifdef WTU_AUTOINC_EN
        next_addr_d = next_addr_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.Start) begin
                    state_d = ST_XFER;
                    idx_d   = '0;
                    op_d    = bus.Op;
                    addr_d  = bus.BaseAddr;
                    wdata_d = bus.WrData;
                end
            end
            ST_XFER: begin
                if (op_q == OP_LOAD) begin
                    for (int unsigned l = 0; l < N; l++) begin
                        if (lane_we[l]) asm_d[8*l +: 8] = bus.MemOut;
                    end
                end
                if (last) begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                    done_d  = 1'b1;
                    // RdData takes the word including this cycle's byte, never a partial one
                    if (op_q == OP_LOAD) rd_d = asm_d;
`ifdef WTU_AUTOINC_EN
                    next_addr_d = addr_q + ADDR_WIDTH'(N);
`endif
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            op_q    <= OP_LOAD;
            addr_q  <= '0;
            wdata_q <= '0;
            asm_q   <= '0;
            rd_q    <= '0;
            done_q  <= 1'b0;
`ifdef WTU_AUTOINC_EN
            next_addr_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            asm_q   <= asm_d;
            rd_q    <= rd_d;
            done_q  <= done_d;
`ifdef WTU_AUTOINC_EN
            next_addr_q <= next_addr_d;
`endif
        end
    end

    assign bus.Busy        = busy;
    assign bus.Done        = done_q;
    assign bus.RdData      = rd_q;
    assign bus.Mem_CS      = ~busy;
    assign bus.Mem_WR      = busy & op_q;
    assign bus.Mem_Address = busy ? (addr_q + ADDR_WIDTH'(idx_q)) : '0;
    assign bus.Mem_Data    = (busy && op_q == OP_STORE) ? lane_byte : '0;
`ifdef WTU_AUTOINC_EN
    assign bus.NextAddr    = next_addr_q;
`endif

endmodule

// File: tb/tb_word_byte_transfer_unit.sv
// Scoreboard bench: 16-bit little-endian and 32-bit big-endian units against byte memory models.
module tb_word_byte_transfer_unit;

    logic clk = 1'b0;
    logic rst16, rst32;
    int unsigned cyc = 0;
    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic             op;
        logic [31:0]      rd;
        int unsigned      done_cyc;
        logic [3:0][15:0] a;
        logic [3:0][7:0]  b;
        logic [15:0]      nxt;
    } exp_t;

    exp_t q16[$];
    exp_t q32[$];

    word_byte_transfer_unit_if #(.DATA_WIDTH(16), .ADDR_WIDTH(16)) if16();
    word_byte_transfer_unit_if #(.DATA_WIDTH(32), .ADDR_WIDTH(16)) if32();

    word_byte_transfer_unit #(.DATA_WIDTH(16), .ADDR_WIDTH(16), .BIG_ENDIAN(1'b0)) u16 (
        .Clock (clk), .Reset (rst16), .bus (if16.slave)
    );
    word_byte_transfer_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .BIG_ENDIAN(1'b1)) u32 (
        .Clock (clk), .Reset (rst32), .bus (if32.slave)
    );

    logic [7:0] mem16 [65536];
    logic [7:0] mem32 [65536];

    assign if16.MemOut = mem16[if16.Mem_Address];
    assign if32.MemOut = mem32[if32.Mem_Address];

    always @(posedge clk) if (!if16.Mem_CS && if16.Mem_WR) mem16[if16.Mem_Address] <= if16.Mem_Data;
    always @(posedge clk) if (!if32.Mem_CS && if32.Mem_WR) mem32[if32.Mem_Address] <= if32.Mem_Data;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Monitors: count busy cycles and write strobes per transfer, compare on Done
    int unsigned b16 = 0, w16 = 0, b32 = 0, w32 = 0;

    always @(negedge clk) begin
        exp_t e;
        if (rst16) begin
            q16.delete(); b16 = 0; w16 = 0;
        end else begin
            if (if16.Busy) b16++;
            if (!if16.Mem_CS && if16.Mem_WR) w16++;
            if (if16.Done) begin
                if (q16.size() == 0) chk("unexpected_done16", 32'd1, 32'd0);
                else begin
                    e = q16.pop_front();
                    chk("done_cycle16", cyc, e.done_cyc);
                    chk("busy_cycles16", b16, 32'd2);
                    chk("write_strobes16", w16, e.op ? 32'd2 : 32'd0);
                    if (e.op) for (int i = 0; i < 2; i++) chk("mem16_byte", 32'(mem16[e.a[i]]), 32'(e.b[i]));
                    else chk("rddata16", 32'(if16.RdData), e.rd);
`ifdef WTU_AUTOINC_EN
                    chk("next_addr16", 32'(if16.NextAddr), 32'(e.nxt));
`endif
                end
                b16 = 0; w16 = 0;
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst32) begin
            q32.delete(); b32 = 0; w32 = 0;
        end else begin
            if (if32.Busy) b32++;
            if (!if32.Mem_CS && if32.Mem_WR) w32++;
            if (if32.Done) begin
                if (q32.size() == 0) chk("unexpected_done32", 32'd1, 32'd0);
                else begin
                    e = q32.pop_front();
                    chk("done_cycle32", cyc, e.done_cyc);
                    chk("busy_cycles32", b32, 32'd4);
                    chk("write_strobes32", w32, e.op ? 32'd4 : 32'd0);
                    if (e.op) for (int i = 0; i < 4; i++) chk("mem32_byte", 32'(mem32[e.a[i]]), 32'(e.b[i]));
                    else chk("rddata32", if32.RdData, e.rd);
`ifdef WTU_AUTOINC_EN
                    chk("next_addr32", 32'(if32.NextAddr), 32'(e.nxt));
`endif
                end
                b32 = 0; w32 = 0;
            end
        end
    end

    // Called at posedge+2; Start is sampled at the next edge.
    task automatic start16(input logic op, input logic [15:0] addr, input logic [15:0] wd,
                           input logic [31:0] rd, input logic [3:0][15:0] a,
                           input logic [3:0][7:0] b, input logic [15:0] nxt);
        exp_t e;
        if16.Start = 1'b1; if16.Op = op; if16.BaseAddr = addr; if16.WrData = wd;
        e.op = op; e.rd = rd; e.done_cyc = cyc + 1 + 2; e.a = a; e.b = b; e.nxt = nxt;
        q16.push_back(e);
        @(posedge clk); #2;
        if16.Start = 1'b0;
    endtask

    task automatic start32(input logic op, input logic [15:0] addr, input logic [31:0] wd,
                           input logic [31:0] rd, input logic [3:0][15:0] a,
                           input logic [3:0][7:0] b, input logic [15:0] nxt);
        exp_t e;
        if32.Start = 1'b1; if32.Op = op; if32.BaseAddr = addr; if32.WrData = wd;
        e.op = op; e.rd = rd; e.done_cyc = cyc + 1 + 4; e.a = a; e.b = b; e.nxt = nxt;
        q32.push_back(e);
        @(posedge clk); #2;
        if32.Start = 1'b0;
    endtask

    task automatic wait16;
        for (int i = 0; i < 40; i++) begin
            if (q16.size() == 0) break;
            @(posedge clk); #2;
        end
        chk("timeout16_pending", q16.size(), 32'd0);
    endtask

    task automatic wait32;
        for (int i = 0; i < 40; i++) begin
            if (q32.size() == 0) break;
            @(posedge clk); #2;
        end
        chk("timeout32_pending", q32.size(), 32'd0);
    endtask

    initial begin
        rst16 = 1'b1; rst32 = 1'b1;
        if16.Start = 1'b0; if16.Op = 1'b0; if16.BaseAddr = '0; if16.WrData = '0;
        if32.Start = 1'b0; if32.Op = 1'b0; if32.BaseAddr = '0; if32.WrData = '0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst16_busy", 32'(if16.Busy), 32'd0);
        chk("rst16_cs", 32'(if16.Mem_CS), 32'd1);
        chk("rst16_wr", 32'(if16.Mem_WR), 32'd0);
        chk("rst16_done", 32'(if16.Done), 32'd0);
        chk("rst16_rddata", 32'(if16.RdData), 32'd0);
        chk("rst16_addr", 32'(if16.Mem_Address), 32'd0);
        chk("rst16_data", 32'(if16.Mem_Data), 32'd0);
        chk("rst32_busy", 32'(if32.Busy), 32'd0);
        chk("rst32_cs", 32'(if32.Mem_CS), 32'd1);
        rst16 = 1'b0; rst32 = 1'b0;
        @(posedge clk); #2;

        // Little-endian 16-bit store and load back
        start16(1'b1, 16'h0010, 16'hABCD, 32'h0, {16'h0, 16'h0, 16'h0011, 16'h0010},
                {8'h0, 8'h0, 8'hAB, 8'hCD}, 16'h0012);
        wait16();
        start16(1'b0, 16'h0010, 16'h0000, 32'h0000ABCD, '0, '0, 16'h0012);
        chk("rddata16_during_xfer0", 32'(if16.RdData), 32'd0);
        @(posedge clk); #2;
        chk("rddata16_during_xfer1", 32'(if16.RdData), 32'd0);
        chk("busy16_in_xfer", 32'(if16.Busy), 32'd1);
        wait16();

        // Address wrap at top of memory
        start16(1'b1, 16'hFFFF, 16'h5AA5, 32'h0, {16'h0, 16'h0, 16'h0000, 16'hFFFF},
                {8'h0, 8'h0, 8'h5A, 8'hA5}, 16'h0001);
        wait16();
        start16(1'b0, 16'hFFFF, 16'h0000, 32'h00005AA5, '0, '0, 16'h0001);
        wait16();

        // Start pulsed mid-transfer with different operands is ignored
        start16(1'b1, 16'h0040, 16'h1234, 32'h0, {16'h0, 16'h0, 16'h0041, 16'h0040},
                {8'h0, 8'h0, 8'h12, 8'h34}, 16'h0042);
        if16.Start = 1'b1; if16.Op = 1'b1; if16.BaseAddr = 16'h0050; if16.WrData = 16'hFFFF;
        @(posedge clk); #2;
        if16.Start = 1'b0;
        wait16();
        chk("ignored_start_no_write", 32'(mem16[16'h0050]), 32'(mem16[16'h0050] === 8'hFF ? 8'h00 : mem16[16'h0050]));

        // Start held in the Done cycle: back-to-back with no gap
        start16(1'b1, 16'h0060, 16'hC3E1, 32'h0, {16'h0, 16'h0, 16'h0061, 16'h0060},
                {8'h0, 8'h0, 8'hC3, 8'hE1}, 16'h0062);
        @(posedge clk); #2;
        @(posedge clk); #2;
        chk("done16_before_b2b", 32'(if16.Done), 32'd1);
        start16(1'b0, 16'h0060, 16'h0000, 32'h0000C3E1, '0, '0, 16'h0062);
        chk("b2b_busy_no_gap", 32'(if16.Busy), 32'd1);
        wait16();

        // Big-endian 32-bit store and load back
        start32(1'b1, 16'h0100, 32'h11223344, 32'h0, {16'h0103, 16'h0102, 16'h0101, 16'h0100},
                {8'h44, 8'h33, 8'h22, 8'h11}, 16'h0104);
        wait32();
        start32(1'b0, 16'h0100, 32'h0, 32'h11223344, '0, '0, 16'h0104);
        wait32();

        // Reset in the second cycle of a 32-bit load
        start32(1'b0, 16'h0100, 32'h0, 32'h11223344, '0, '0, 16'h0104);
        @(posedge clk); #2;
        rst32 = 1'b1;
        @(posedge clk); #2;
        chk("abort_busy", 32'(if32.Busy), 32'd0);
        chk("abort_cs", 32'(if32.Mem_CS), 32'd1);
        chk("abort_done", 32'(if32.Done), 32'd0);
        chk("abort_rddata", if32.RdData, 32'd0);
        chk("abort_addr", 32'(if32.Mem_Address), 32'd0);
        rst32 = 1'b0;
        @(posedge clk); #2;
        start32(1'b0, 16'h0100, 32'h0, 32'h11223344, '0, '0, 16'h0104);
        wait32();

        repeat (3) @(posedge clk);
        #2;
        chk("final_idle16", 32'(if16.Busy), 32'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
